// File: rtl/ide.sv
// IDE PIO register-access engine: sequences CS/DA setup, DIOR-/DIOW- strobe and hold,
// writes latched data onto DD[15:0] and captures read data at the end of the strobe.
module ide #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 6,
    parameter int T_HOLD   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ata_rd,
    input  logic        ata_wr,
    input  logic [4:0]  ata_addr,
    input  logic [15:0] ata_in,
    output logic [15:0] ata_out,
    output logic        ata_done,
    inout  wire  [15:0] ide_data_bus,
    output logic        ide_dior,
    output logic        ide_diow,
    output logic [1:0]  ide_cs,
    output logic [2:0]  ide_da
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic        last;
    logic        op_rd;
    logic [4:0]  addr_q;
    logic [15:0] din_q;
    logic        drive;
    logic        req;

    assign req = ata_rd | ata_wr;

    // Tri-state DD driver: only a latched write drives the bus.
    assign ide_data_bus = drive ? din_q : 16'hzzzz;

    // Terminal count of the shared phase counter for the current state.
    always_comb begin
        last = 1'b0;
        unique case (state)
            SETUP:   last = (cnt == 8'(T_SETUP - 1));
            STROBE:  last = (cnt == 8'(T_STROBE - 1));
            HOLD:    last = (cnt == 8'(T_HOLD - 1));
            default: last = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req)  state_nx = SETUP;
            SETUP:   if (last) state_nx = STROBE;
            STROBE:  if (last) state_nx = HOLD;
            HOLD:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt <= '0;
        else if (state_nx != state) cnt <= '0;
        else if (state != IDLE)     cnt <= cnt + 8'd1;
    end

    // Latch operation, address and write data when a request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_rd  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (state == IDLE && req) begin
            op_rd  <= ata_rd;
            addr_q <= ata_addr;
            din_q  <= ata_in;
        end
    end

    // Capture read data on the edge that ends the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             ata_out <= '0;
        else if (state == STROBE && last && op_rd) ata_out <= ide_data_bus;
    end

    // Output decode from the registered state.
    always_comb begin
        ide_cs   = 2'b11;
        ide_da   = 3'b000;
        ide_dior = 1'b1;
        ide_diow = 1'b1;
        drive    = 1'b0;
        ata_done = 1'b0;
        unique case (state)
            SETUP: begin
                ide_cs = addr_q[4:3];
                ide_da = addr_q[2:0];
                drive  = ~op_rd;
            end
            STROBE: begin
                ide_cs   = addr_q[4:3];
                ide_da   = addr_q[2:0];
                ide_dior = ~op_rd;
                ide_diow = op_rd;
                drive    = ~op_rd;
            end
            HOLD: begin
                ide_cs = addr_q[4:3];
                ide_da = addr_q[2:0];
                drive  = ~op_rd;
            end
            DONE: begin
                ide_cs   = addr_q[4:3];
                ide_da   = addr_q[2:0];
                ata_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ide.sv
// Bench for ide: directed transactions, scoreboard of expected completions
// checked by an independent monitor on ata_done.
module tb_ide;

    logic        clk;
    logic        reset;
    logic        ata_rd;
    logic        ata_wr;
    logic [4:0]  ata_addr;
    logic [15:0] ata_in;
    logic [15:0] ata_out;
    logic        ata_done;
    wire  [15:0] ide_data_bus;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;

    logic        dev_en;
    logic [15:0] dev_data;

    int checks;
    int errors;
    int cyc;

    logic [15:0] model_out;

    typedef struct {
        int          cyc;
        logic [15:0] out;
        logic [1:0]  cs;
        logic [2:0]  da;
    } exp_t;

    exp_t q[$];

    localparam int LAT = 2 + 6 + 2 + 1;

    assign ide_data_bus = dev_en ? dev_data : 16'hzzzz;

    ide dut (
        .clk          (clk),
        .reset        (reset),
        .ata_rd       (ata_rd),
        .ata_wr       (ata_wr),
        .ata_addr     (ata_addr),
        .ata_in       (ata_in),
        .ata_out      (ata_out),
        .ata_done     (ata_done),
        .ide_data_bus (ide_data_bus),
        .ide_dior     (ide_dior),
        .ide_diow     (ide_diow),
        .ide_cs       (ide_cs),
        .ide_da       (ide_da)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset && ata_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(cyc), 32'hffffffff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.cyc));
                chk("ata_out", {16'h0, ata_out}, {16'h0, e.out});
                chk("done_cs", {30'h0, ide_cs}, {30'h0, e.cs});
                chk("done_da", {29'h0, ide_da}, {29'h0, e.da});
            end
        end
    end

    task automatic push_exp(input int c, input logic [15:0] o,
                            input logic [1:0] cs, input logic [2:0] da);
        exp_t e;
        e.cyc = c;
        e.out = o;
        e.cs  = cs;
        e.da  = da;
        q.push_back(e);
    endtask

    // One full transaction with per-cycle waveform checks.
    task automatic xfer(input logic rd, input logic wr, input logic [4:0] addr,
                        input logic [15:0] din, input logic [15:0] dev,
                        input logic [1:0] ecs, input logic [2:0] eda);
        int n_rd;
        int n_wr;
        int bad_rd;
        int bad_wr;
        int bad_sel;
        int bad_bus;
        int both;
        bit wonly;
        logic e_rd;
        logic e_wr;
        wonly = wr && !rd;
        n_rd = 0; n_wr = 0; bad_rd = 0; bad_wr = 0;
        bad_sel = 0; bad_bus = 0; both = 0;
        @(negedge clk);
        ata_rd   = rd;
        ata_wr   = wr;
        ata_addr = addr;
        ata_in   = din;
        dev_data = dev;
        dev_en   = !wonly;
        if (rd) model_out = dev;
        push_exp(cyc + LAT, model_out, ecs, eda);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) begin
                ata_addr = ~addr;
                ata_in   = ~din;
            end
            e_rd = !(rd && k >= 3 && k <= 8);
            e_wr = !(wonly && k >= 3 && k <= 8);
            if (!ide_dior) n_rd++;
            if (!ide_diow) n_wr++;
            if (ide_dior !== e_rd) bad_rd++;
            if (ide_diow !== e_wr) bad_wr++;
            if (!ide_dior && !ide_diow) both++;
            if (k <= 11) begin
                if (ide_cs !== ecs || ide_da !== eda) bad_sel++;
            end else begin
                if (ide_cs !== 2'b11 || ide_da !== 3'b000) bad_sel++;
            end
            if (wonly && k <= 10) begin
                if (ide_data_bus !== din) bad_bus++;
            end else begin
                if (ide_data_bus !== dev_data) bad_bus++;
            end
            if (wonly && k == 10) begin
                dev_en   = 1'b1;
                dev_data = 16'h1234;
            end
            if (k == 11) begin
                ata_rd = 1'b0;
                ata_wr = 1'b0;
            end
        end
        chk("dior_low_cnt", 32'(n_rd), rd ? 32'd6 : 32'd0);
        chk("diow_low_cnt", 32'(n_wr), wonly ? 32'd6 : 32'd0);
        chk("dior_wave", 32'(bad_rd), 32'd0);
        chk("diow_wave", 32'(bad_wr), 32'd0);
        chk("strobe_overlap", 32'(both), 32'd0);
        chk("cs_da_wave", 32'(bad_sel), 32'd0);
        chk("bus_wave", 32'(bad_bus), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_out = 16'h0000;
        reset     = 1'b0;
        ata_rd    = 1'b0;
        ata_wr    = 1'b0;
        ata_addr  = 5'b11000;
        ata_in    = 16'h0000;
        dev_en    = 1'b1;
        dev_data  = 16'h1234;

        repeat (3) @(negedge clk);
        chk("rst_dior", {31'h0, ide_dior}, 32'd1);
        chk("rst_diow", {31'h0, ide_diow}, 32'd1);
        chk("rst_cs", {30'h0, ide_cs}, 32'h3);
        chk("rst_da", {29'h0, ide_da}, 32'h0);
        chk("rst_done", {31'h0, ata_done}, 32'd0);
        chk("rst_out", {16'h0, ata_out}, 32'h0);
        chk("rst_bus_z", {16'h0, ide_data_bus}, 32'h1234);
        reset = 1'b1;

        // Status read, drive/head write, altstatus read, rd+wr priority.
        xfer(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0050, 2'b10, 3'b111);
        xfer(1'b0, 1'b1, 5'b10110, 16'h0040, 16'h1234, 2'b10, 3'b110);
        xfer(1'b1, 1'b0, 5'b01110, 16'h0000, 16'h00d0, 2'b01, 3'b110);
        xfer(1'b1, 1'b1, 5'b10000, 16'haaaa, 16'h1357, 2'b10, 3'b000);

        // Held read over three back-to-back status polls.
        begin
            int n;
            @(negedge clk);
            n        = cyc;
            ata_rd   = 1'b1;
            ata_addr = 5'b10111;
            dev_en   = 1'b1;
            dev_data = 16'h0051;
            push_exp(n + LAT, 16'h0051, 2'b10, 3'b111);
            push_exp(n + 2 * LAT + 1, 16'h0052, 2'b10, 3'b111);
            push_exp(n + 3 * LAT + 2, 16'h0053, 2'b10, 3'b111);
            model_out = 16'h0053;
            for (int k = 1; k <= 37; k++) begin
                @(negedge clk);
                if (k == 11) dev_data = 16'h0052;
                if (k == 23) dev_data = 16'h0053;
                if (k == 35) ata_rd = 1'b0;
                if (k == 12 || k == 24)
                    chk("poll_idle_gap", {29'h0, ide_cs, ata_done}, 32'h6);
                if (k == 13 || k == 25)
                    chk("poll_restart", {30'h0, ide_cs}, 32'h2);
            end
        end

        // Reset in the middle of a write strobe aborts the cycle.
        @(negedge clk);
        ata_wr   = 1'b1;
        ata_addr = 5'b10000;
        ata_in   = 16'hbeef;
        dev_en   = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_strobe_diow", {31'h0, ide_diow}, 32'd0);
        #2;
        reset    = 1'b0;
        dev_en   = 1'b1;
        dev_data = 16'h1234;
        #1;
        chk("abort_diow", {31'h0, ide_diow}, 32'd1);
        chk("abort_dior", {31'h0, ide_dior}, 32'd1);
        chk("abort_cs", {30'h0, ide_cs}, 32'h3);
        chk("abort_da", {29'h0, ide_da}, 32'h0);
        chk("abort_bus_z", {16'h0, ide_data_bus}, 32'h1234);
        chk("abort_done", {31'h0, ata_done}, 32'd0);
        chk("abort_out", {16'h0, ata_out}, 32'h0);
        model_out = 16'h0000;
        ata_wr    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        chk("abort_no_done", 32'(q.size()), 32'd0);

        xfer(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0058, 2'b10, 3'b111);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ide.md
IDE -- requirements
Module: ide

Interface
REQ-001 SHALL have parameter T_SETUP, default 2: clocks that address/CS are valid before the strobe.
REQ-002 SHALL have parameter T_STROBE, default 6: clocks that DIOR-/DIOW- is held low.
REQ-003 SHALL have parameter T_HOLD, default 2: clocks that address/CS/write data are held after the strobe.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ata_rd  input  1  read request; level, held by the requester until ata_done.
REQ-007 ata_wr  input  1  write request; level, held by the requester until ata_done.
REQ-008 ata_addr  input  5  {cs1_n, cs0_n, da[2:0]} register select, e.g. 10000 = data, 10111 = status/command, 01110 = altstatus/devctrl.
REQ-009 ata_in  input  16  write data.
REQ-010 ata_out  output  16  last read data.
REQ-011 ata_done  output  1  one-clock completion pulse.
REQ-012 ide_data_bus  inout  16  IDE DD[15:0].
REQ-013 ide_dior  output  1  DIOR-, active low.
REQ-014 ide_diow  output  1  DIOW-, active low.
REQ-015 ide_cs  output  2  {CS1-, CS0-}, active low.
REQ-016 ide_da  output  3  DA[2:0].

Function
REQ-017 SHALL implement registered states IDLE, SETUP, STROBE, HOLD, DONE, with one shared cycle counter.
REQ-018 IDLE: if ata_rd or ata_wr is sampled high, SHALL do all of the following on that edge, then enter SETUP:
- latch the operation (read wins if both are high), ata_addr and ata_in;
- drive ide_cs = latched addr[4:3] and ide_da = addr[2:0].
REQ-019 SETUP SHALL last T_SETUP clocks, then enter STROBE; the strobe goes low on the entry edge (ide_dior for read, ide_diow for write).
REQ-020 STROBE SHALL last T_STROBE clocks. On its final edge the strobe SHALL return high, the block SHALL enter HOLD, and on a read ide_data_bus SHALL be captured into ata_out.
REQ-021 HOLD SHALL last T_HOLD clocks with cs/da unchanged, then enter DONE.
REQ-022 DONE SHALL last one clock, with ata_done = 1 only in that state, and SHALL then enter IDLE.
- On entry to IDLE, ide_cs SHALL return to 11 and ide_da to 000.
REQ-023 Latency: ata_done SHALL be high exactly T_SETUP+T_STROBE+T_HOLD+1 clocks after the accepting edge (11 clocks with the default parameters).
REQ-024 Write: ide_data_bus SHALL be driven with the latched ata_in from SETUP through HOLD; it SHALL be high-Z at all other times.
REQ-025 Read: the bus SHALL never be driven by this block.
REQ-026 ata_out SHALL hold its value until the next read capture; writes SHALL not alter it.
REQ-027 Changes to ata_rd/ata_wr/ata_addr/ata_in after acceptance SHALL be ignored until IDLE.
REQ-028 A request still high in the IDLE cycle after DONE SHALL start a new transaction (supports status polling); there SHALL be no back-to-back overlap.
REQ-029 ide_dior and ide_diow SHALL never be low simultaneously.

Reset
REQ-030 reset low SHALL asynchronously force:
- state IDLE, counter 0;
- ide_dior = 1, ide_diow = 1, ide_cs = 11, ide_da = 000;
- bus high-Z, ata_done = 0, ata_out = 0000.
REQ-031 Reset during any phase SHALL abort the cycle with no ata_done pulse.
- Operation SHALL resume on the first edge after reset releases, with the request sampled in IDLE.

Verification
REQ-032 Read status: ata_rd = 1, addr 10111, device drives 0x0050 -> cs = 10, da = 111, dior low 6 clocks, ata_out = 0x0050, single ata_done 11 clocks after acceptance.
REQ-033 Write drvhead: ata_wr = 1, addr 10110, ata_in = 0x0040 -> bus = 0x0040 from SETUP to HOLD, diow low 6 clocks, dior stays high, bus Z after DONE.
REQ-034 Alt status: addr 01110 read -> cs = 01, da = 110.
REQ-035 Held ata_rd over 3 transactions -> 3 ata_done pulses, each separated by one IDLE clock; ata_out updates each time.
REQ-036 rd and wr both high -> read performed, diow stays high.
REQ-037 reset asserted mid-STROBE -> strobes high, cs = 11, bus Z immediately, no ata_done; next request completes normally.
